// File: rtl/mux_adc_pkg.sv
// Shared types and constants for the multiplexed ADC capture block.
// Frame length is the ADC result plus the leading pad bits the converter emits.
package mux_adc_pkg;

   localparam int CH_W      = 5;
   localparam int FRAME_PAD = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CONVERT,
      ST_DONE
   } state_e;

   function automatic int frame_bits(input int adc_bits);
      return adc_bits + FRAME_PAD;
   endfunction

endpackage

// File: rtl/mux_adc_capture_spi_frame.sv
// Serial frame engine: one start pulse runs FRAME_BITS full sclk periods,
// sampling miso at each sclk rise; done pulses in the last active cycle.
module adc_spi_frame #(
   parameter int SCLK_DIV   = 4,
   parameter int ADC_BITS   = 12,
   parameter int FRAME_BITS = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                miso,
   output logic                sclk,
   output logic                done,
   output logic [ADC_BITS-1:0] data
);

   localparam int              BW       = $clog2(FRAME_BITS + 1);
   localparam logic [7:0]      DIV_LAST = 8'(SCLK_DIV - 1);
   localparam logic [BW-1:0]   BIT_LAST = BW'(FRAME_BITS - 1);

   logic                active_q, active_d;
   logic                sclk_q, sclk_d;
   logic [7:0]          div_q, div_d;
   logic [BW-1:0]       bit_q, bit_d;
   logic [ADC_BITS-1:0] shift_q, shift_d;
   logic                half_end;

   assign half_end = (div_q == DIV_LAST);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      active_d = active_q;
      sclk_d   = sclk_q;
      div_d    = div_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      done     = 1'b0;
      if (start) begin
         active_d = 1'b1;
         sclk_d   = 1'b0;
         div_d    = '0;
         bit_d    = '0;
         shift_d  = '0;
      end else if (active_q) begin
         if (half_end) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
               // Shifting the whole frame through a result-wide register drops the pad bits.
               shift_d = {shift_q[ADC_BITS-2:0], miso};
            end else begin
               bit_d = bit_q + 1'b1;
               if (bit_q == BIT_LAST) begin
                  active_d = 1'b0;
                  done     = 1'b1;
               end
            end
         end else begin
            div_d = div_q + 8'd1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignment so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         sclk_q   <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
      end else begin
         active_q <= active_d;
         sclk_q   <= sclk_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
      end
   end

   assign sclk = sclk_q;
   assign data = shift_q;

endmodule

// File: rtl/mux_adc_capture.sv
// Captures one ADC conversion per multiplexer channel change: waits for the
// analog path to settle, runs a serial frame and presents a tagged sample.
module mux_adc_capture
   import mux_adc_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter int SCLK_DIV      = 4,
   parameter int ADC_BITS      = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mux_wr,
   input  logic [CH_W-1:0]     mux_ch,
   input  logic                adc_miso,
   output logic                adc_sclk,
   output logic                adc_cs_n,
   output logic [ADC_BITS-1:0] sample_data,
   output logic [CH_W-1:0]     sample_ch,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic                overrun
);

   localparam int            FRAME_BITS  = frame_bits(ADC_BITS);
   localparam int            SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   logic [1:0]          rst_sync_q, rst_sync_d;
   logic                rst_int_n;
   state_e              state_q, state_d;
   logic                mux_wr_q, mux_wr_d;
   logic [SW-1:0]       settle_q, settle_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic                pend_q, pend_d;
   logic [CH_W-1:0]     pend_ch_q, pend_ch_d;
   logic [ADC_BITS-1:0] data_q, data_d;
   logic [CH_W-1:0]     sch_q, sch_d;
   logic                valid_q, valid_d;
   logic                ovr_q, ovr_d;
   logic                wr_edge;
   logic                spi_start, spi_done;
   logic [ADC_BITS-1:0] spi_data;

   // Reset asserts immediately but releases only on a clk edge.
   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= '0;
      else        rst_sync_q <= rst_sync_d;
   end
   assign rst_int_n = rst_sync_q[1];

   assign wr_edge = mux_wr & ~mux_wr_q;

   always_comb begin
      state_d   = state_q;
      mux_wr_d  = mux_wr;
      settle_d  = settle_q;
      ch_d      = ch_q;
      pend_d    = pend_q;
      pend_ch_d = pend_ch_q;
      data_d    = data_q;
      sch_d     = sch_q;
      valid_d   = valid_q;
      ovr_d     = 1'b0;
      spi_start = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (wr_edge) begin
               ch_d     = mux_ch;
               settle_d = '0;
               if (SETTLE_CYCLES == 0) begin
                  state_d   = ST_CONVERT;
                  spi_start = 1'b1;
               end else begin
                  state_d = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (wr_edge) begin
               ch_d     = mux_ch;
               settle_d = '0;
            end else if (settle_q == SETTLE_LAST) begin
               state_d   = ST_CONVERT;
               spi_start = 1'b1;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         ST_CONVERT: begin
            if (wr_edge) begin
               pend_d    = 1'b1;
               pend_ch_d = mux_ch;
               ovr_d     = pend_q;
            end
            if (spi_done) state_d = ST_DONE;
         end
         ST_DONE: begin
            // An edge arriving in DONE itself is treated as the newest pending event.
            if (pend_q || wr_edge) begin
               ch_d     = wr_edge ? mux_ch : pend_ch_q;
               ovr_d    = pend_q & wr_edge;
               pend_d   = 1'b0;
               settle_d = '0;
               if (SETTLE_CYCLES == 0) begin
                  state_d   = ST_CONVERT;
                  spi_start = 1'b1;
               end else begin
                  state_d = ST_SETTLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q == ST_DONE) begin
         data_d  = spi_data;
         sch_d   = ch_q;
         valid_d = 1'b1;
         if (valid_q && !sample_ready) ovr_d = 1'b1;
      end else if (valid_q && sample_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q   <= ST_IDLE;
         mux_wr_q  <= 1'b0;
         settle_q  <= '0;
         ch_q      <= '0;
         pend_q    <= 1'b0;
         pend_ch_q <= '0;
         data_q    <= '0;
         sch_q     <= '0;
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mux_wr_q  <= mux_wr_d;
         settle_q  <= settle_d;
         ch_q      <= ch_d;
         pend_q    <= pend_d;
         pend_ch_q <= pend_ch_d;
         data_q    <= data_d;
         sch_q     <= sch_d;
         valid_q   <= valid_d;
         ovr_q     <= ovr_d;
      end
   end

   adc_spi_frame #(
      .SCLK_DIV  (SCLK_DIV),
      .ADC_BITS  (ADC_BITS),
      .FRAME_BITS(FRAME_BITS)
   ) u_spi (
      .clk  (clk),
      .rst_n(rst_int_n),
      .start(spi_start),
      .miso (adc_miso),
      .sclk (adc_sclk),
      .done (spi_done),
      .data (spi_data)
   );

   assign adc_cs_n     = (state_q != ST_CONVERT);
   assign sample_data  = data_q;
   assign sample_ch    = sch_q;
   assign sample_valid = valid_q;
   assign overrun      = ovr_q;

endmodule
